sync_fifo_param: RTL and testbench

Synchronous single-clock FIFO with configurable data width and depth. It is the successor to the team's fixed 8x16 FIFO.
- Adds concurrent read+write in one cycle, a live fill-level output, and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode.
- Used as the general buffering primitive between producer/consumer blocks on one clock domain.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ram.sv | 25 ++
 rtl/sync_fifo_param.sv | 115 +++++++++++
 tb/tb_sync_fifo_param.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised synchronous FIFO.
package fifo_pkg;

  // Width of the fill-level counter; one extra bit so DEPTH itself fits.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Legal parameter set: power-of-two depth >= 4, thresholds strictly inside the range.
  function automatic bit fifo_params_ok(input int data_w, input int depth,
                                        input int af, input int ae);
    return (data_w >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth - 1) && (ae >= 1) && (ae <= depth - 1);
  endfunction

  // Status bundle presented by the FIFO.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Write port: store on accepted write only.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill level, programmable almost flags, sticky
// overflow/underflow and optional first-word-fall-through output.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         din,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  if (!fifo_params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_err
    $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [AW-1:0]     wptr, rptr;
  logic [DATA_W-1:0] ram_rdata;
  logic              wr_acc, rd_acc;
  fifo_status_t      st;

  // Flags decode the count register only; pointers may be equal when full or empty.
  assign st.full         = (count == FULL_CNT);
  assign st.empty        = (count == '0);
  assign st.almost_full  = (count >= AF_CNT);
  assign st.almost_empty = (count <= AE_CNT);
  assign st.overflow     = overflow;
  assign st.underflow    = underflow;

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;

  // Acceptance is judged on start-of-cycle state, so empty+rd+wr writes only
  // and full+rd+wr reads only.
  assign wr_acc = wr_en && !st.full;
  assign rd_acc = rd_en && !st.empty;

  fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (din),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  // Pointer and fill-level update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new violation beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && st.full) overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;
      if (rd_en && st.empty) underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is visible as soon as it is stored; don't-care while empty.
    assign dout = ram_rdata;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;

    // Registered read: word appears the cycle after an accepted read, else holds.
    always_ff @(posedge clk) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= ram_rdata;
    end

    assign dout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: one standard-read instance and one
// FWFT instance, driven by directed vectors.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-read instance signals
  logic       rst0 = 1'b0, wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0;
  logic [7:0] din0 = '0, dout0;
  logic       full0, empty0, af0, ae0, ov0_o, un0_o;
  logic [4:0] cnt0;

  // FWFT instance signals
  logic       rst1 = 1'b0, wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
  logic [7:0] din1 = '0, dout1;
  logic       full1, empty1, af1, ae1, ov1_o, un1_o;
  logic [4:0] cnt1;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst0), .wr_en(wr0), .din(din0), .rd_en(rd0), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ov0_o), .underflow(un0_o), .clr_err(clr0)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst1), .wr_en(wr1), .din(din1), .rd_en(rd1), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ov1_o), .underflow(un1_o), .clr_err(clr1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference models: stored words, sticky flags, expected read data
  logic [7:0] q0[$], q1[$], exp0_q[$];
  bit         m_ov0, m_un0, m_ov1, m_un1;
  bit         fire0, pend0, armed0, armed1;
  logic [7:0] last0;

  // Standard mode monitor: a read accepted at an edge must present its word
  // by the following negedge; otherwise dout must hold.
  always @(posedge clk) pend0 <= fire0;

  always @(negedge clk) begin
    if (armed0) begin
      if (pend0) begin
        if (exp0_q.size() == 0) chk("std_rd_unexpected", 1, 0);
        else begin
          last0 = exp0_q.pop_front();
          chk("std_rd_data", {24'd0, dout0}, {24'd0, last0});
        end
      end else begin
        chk("std_dout_hold", {24'd0, dout0}, {24'd0, last0});
      end
    end
  end

  // FWFT monitor: head word is visible whenever the FIFO holds data.
  always @(negedge clk) begin
    if (armed1 && q1.size() > 0)
      chk("fwft_head", {24'd0, dout1}, {24'd0, q1[0]});
  end

  task automatic step0(input bit r, input bit w, input logic [7:0] d, input bit rd, input bit c);
    bit f, e, wa, ra;
    f  = (q0.size() == 16);
    e  = (q0.size() == 0);
    wa = w && !f;
    ra = rd && !e;
    rst0 = r; wr0 = w; din0 = d; rd0 = rd; clr0 = c;
    fire0 = ra && !r;
    @(posedge clk); #1;
    fire0 = 1'b0;
    if (r) begin
      q0.delete(); exp0_q.delete(); m_ov0 = 0; m_un0 = 0; last0 = '0;
    end else begin
      if (w && f) m_ov0 = 1; else if (c) m_ov0 = 0;
      if (rd && e) m_un0 = 1; else if (c) m_un0 = 0;
      if (ra) exp0_q.push_back(q0.pop_front());
      if (wa) q0.push_back(d);
    end
    chk("std_count", cnt0,   q0.size());
    chk("std_full",  full0,  q0.size() == 16);
    chk("std_empty", empty0, q0.size() == 0);
    chk("std_af",    af0,    q0.size() >= 14);
    chk("std_ae",    ae0,    q0.size() <= 2);
    chk("std_ovf",   ov0_o,  m_ov0);
    chk("std_unf",   un0_o,  m_un0);
    rst0 = 0; wr0 = 0; rd0 = 0; clr0 = 0;
  endtask

  task automatic step1(input bit r, input bit w, input logic [7:0] d, input bit rd, input bit c);
    bit f, e, wa, ra;
    f  = (q1.size() == 16);
    e  = (q1.size() == 0);
    wa = w && !f;
    ra = rd && !e;
    rst1 = r; wr1 = w; din1 = d; rd1 = rd; clr1 = c;
    @(posedge clk); #1;
    if (r) begin
      q1.delete(); m_ov1 = 0; m_un1 = 0;
    end else begin
      if (w && f) m_ov1 = 1; else if (c) m_ov1 = 0;
      if (rd && e) m_un1 = 1; else if (c) m_un1 = 0;
      if (ra) void'(q1.pop_front());
      if (wa) q1.push_back(d);
    end
    chk("fwft_count", cnt1,   q1.size());
    chk("fwft_full",  full1,  q1.size() == 16);
    chk("fwft_empty", empty1, q1.size() == 0);
    chk("fwft_af",    af1,    q1.size() >= 14);
    chk("fwft_ae",    ae1,    q1.size() <= 2);
    chk("fwft_ovf",   ov1_o,  m_ov1);
    chk("fwft_unf",   un1_o,  m_un1);
    rst1 = 0; wr1 = 0; rd1 = 0; clr1 = 0;
  endtask

  initial begin
    // Reset then idle
    step0(1, 0, 8'h00, 0, 0);
    armed0 = 1;
    step0(0, 0, 8'h00, 0, 0);

    // Fill with 0x01..0x10; almost_full at 14, full at 16
    for (int i = 1; i <= 16; i++) step0(0, 1, 8'(i), 0, 0);

    // Write while full is rejected and flags overflow; clear it
    step0(0, 1, 8'hAA, 0, 0);
    step0(0, 0, 8'h00, 0, 1);

    // Full + write + read: read only, overflow still flagged
    step0(0, 1, 8'hBB, 1, 0);
    step0(0, 0, 8'h00, 0, 1);

    // Drain remaining words 0x02..0x10
    for (int i = 0; i < 15; i++) step0(0, 0, 8'h00, 1, 0);
    step0(0, 0, 8'h00, 0, 0);

    // Underflow on empty; clear in the same cycle as a new violation keeps it set
    step0(0, 0, 8'h00, 1, 0);
    step0(0, 0, 8'h00, 1, 1);
    step0(0, 0, 8'h00, 0, 1);

    // Empty + write + read: write only, underflow flagged
    step0(0, 1, 8'h33, 1, 0);
    step0(0, 0, 8'h00, 1, 1);

    // Hold count at 8 with 40 concurrent read/write cycles; pointers wrap
    for (int i = 0; i < 8; i++) step0(0, 1, 8'(8'h20 + i), 0, 0);
    for (int i = 0; i < 40; i++) step0(0, 1, 8'(8'h28 + i), 1, 0);
    for (int i = 0; i < 8; i++) step0(0, 0, 8'h00, 1, 0);
    step0(0, 0, 8'h00, 0, 0);

    // FWFT instance
    step1(1, 0, 8'h00, 0, 0);
    armed1 = 1;
    step1(0, 1, 8'h5A, 0, 0);
    step1(0, 0, 8'h00, 0, 0);
    step1(0, 0, 8'h00, 1, 0);

    // Reset mid-stream at count 5 discards everything
    for (int i = 0; i < 5; i++) step1(0, 1, 8'(8'h61 + i), 0, 0);
    step1(1, 0, 8'h00, 0, 0);
    step1(0, 1, 8'h70, 0, 0);
    step1(0, 1, 8'h71, 0, 0);
    step1(0, 0, 8'h00, 1, 0);
    step1(0, 0, 8'h00, 1, 0);
    step1(0, 0, 8'h00, 1, 0);

    @(negedge clk); #1;
    if (exp0_q.size() != 0) chk("std_rd_missing", exp0_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
